// File: rtl/scoreboard_register_file_if.sv
// scoreboard_register_file_if
//   Groups the writeback, reserve and read signals of the scoreboard register
//   file. Clock and Reset are kept out of the bundle.
//   master : the pipeline side (decode + writeback sources); it drives the
//            write/reserve/read-index signals and observes read data/busy.
//   slave  : the register file itself.
//   All strobes (WriteEnableA/B, ReserveEnable) are single-cycle qualifiers
//   sampled on the rising edge; there is no back-pressure. The register file
//   accepts every strobe in the cycle it is presented, so no ready exists.
interface scoreboard_register_file_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] WriteDataA;
    logic [ADDR_WIDTH-1:0] WriteTargetA;
    logic                  WriteEnableA;
    logic [DATA_WIDTH-1:0] WriteDataB;
    logic [ADDR_WIDTH-1:0] WriteTargetB;
    logic                  WriteEnableB;
    logic                  ReserveEnable;
    logic [ADDR_WIDTH-1:0] ReserveTarget;
    logic [ADDR_WIDTH-1:0] ReadSourceA;
    logic [ADDR_WIDTH-1:0] ReadSourceB;
    logic [DATA_WIDTH-1:0] ReadPortA;
    logic [DATA_WIDTH-1:0] ReadPortB;
    logic                  ReadBusyA;
    logic                  ReadBusyB;
    logic [ADDR_WIDTH:0]   BusyCount;
    logic                  WriteConflict;

    modport master (
        output WriteDataA, WriteTargetA, WriteEnableA,
        output WriteDataB, WriteTargetB, WriteEnableB,
        output ReserveEnable, ReserveTarget,
        output ReadSourceA, ReadSourceB,
        input  ReadPortA, ReadPortB, ReadBusyA, ReadBusyB,
        input  BusyCount, WriteConflict
    );

    modport slave (
        input  WriteDataA, WriteTargetA, WriteEnableA,
        input  WriteDataB, WriteTargetB, WriteEnableB,
        input  ReserveEnable, ReserveTarget,
        input  ReadSourceA, ReadSourceB,
        output ReadPortA, ReadPortB, ReadBusyA, ReadBusyB,
        output BusyCount, WriteConflict
    );
endinterface

// File: rtl/scoreboard_register_file.sv
// scoreboard_register_file
//   Two-write / two-read register file with a pending bit per register.
//   Decode reserves destinations (ReserveEnable/ReserveTarget) and reads
//   operands (ReadSourceA/B); the ALU (port A) and load (port B) writeback
//   paths commit results and release reservations.
//   Ports:
//     Clock  - rising-edge clock for all state
//     Reset  - asynchronous active-high clear of storage, pending bits,
//              BusyCount and WriteConflict
//     bus    - slave modport of scoreboard_register_file_if (write ports,
//              reserve port, read indices, read data/busy, BusyCount,
//              WriteConflict)
//   Read data is bypassed from same-cycle writes (A over B over storage).
module scoreboard_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit ZERO_REG   = 1'b1
) (
    input logic Clock,
    input logic Reset,
    scoreboard_register_file_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] storage [DEPTH];
    logic [DEPTH-1:0]      pending;
    logic [DEPTH-1:0]      pending_next;
    logic [ADDR_WIDTH:0]   busy_count;
    logic [ADDR_WIDTH:0]   busy_count_next;
    logic                  write_conflict;

    logic eff_a, eff_b_raw, eff_b, eff_res, same_target;
    logic res_sets, a_clears, b_clears;

    // A register index is "live" unless it is the hardwired zero register.
    function automatic logic is_live(input logic [ADDR_WIDTH-1:0] idx);
        return !(ZERO_REG && (idx == '0));
    endfunction

    // Effective strobes. Reset suppresses them so that bypass and busy
    // outputs reflect the cleared state while Reset is held.
    always_comb begin
        eff_a       = bus.WriteEnableA && is_live(bus.WriteTargetA) && !Reset;
        eff_b_raw   = bus.WriteEnableB && is_live(bus.WriteTargetB) && !Reset;
        same_target = eff_a && eff_b_raw && (bus.WriteTargetA == bus.WriteTargetB);
        eff_b       = eff_b_raw && !same_target;   // port A wins a collision
        eff_res     = bus.ReserveEnable && is_live(bus.ReserveTarget) && !Reset;
    end

    // Reserve is applied after the write clears: a new producer issued on the
    // same edge as the old producer's writeback keeps the register pending.
    always_comb begin
        pending_next = pending;
        if (eff_a)   pending_next[bus.WriteTargetA]  = 1'b0;
        if (eff_b)   pending_next[bus.WriteTargetB]  = 1'b0;
        if (eff_res) pending_next[bus.ReserveTarget] = 1'b1;
    end

    // Incremental popcount. eff_b already excludes A's target, so a single
    // register is never decremented twice.
    always_comb begin
        res_sets = eff_res && !pending[bus.ReserveTarget];
        a_clears = eff_a && pending[bus.WriteTargetA] &&
                   !(eff_res && (bus.ReserveTarget == bus.WriteTargetA));
        b_clears = eff_b && pending[bus.WriteTargetB] &&
                   !(eff_res && (bus.ReserveTarget == bus.WriteTargetB));
        busy_count_next = busy_count
                        + {{ADDR_WIDTH{1'b0}}, res_sets}
                        - {{ADDR_WIDTH{1'b0}}, a_clears}
                        - {{ADDR_WIDTH{1'b0}}, b_clears};
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
            pending        <= '0;
            busy_count     <= '0;
            write_conflict <= 1'b0;
        end else begin
            if (eff_a) storage[bus.WriteTargetA] <= bus.WriteDataA;
            if (eff_b) storage[bus.WriteTargetB] <= bus.WriteDataB;
            pending        <= pending_next;
            busy_count     <= busy_count_next;
            write_conflict <= same_target;
        end
    end

    always_comb begin
        if (!is_live(bus.ReadSourceA))                            bus.ReadPortA = '0;
        else if (eff_a && (bus.WriteTargetA == bus.ReadSourceA)) bus.ReadPortA = bus.WriteDataA;
        else if (eff_b && (bus.WriteTargetB == bus.ReadSourceA)) bus.ReadPortA = bus.WriteDataB;
        else                                                      bus.ReadPortA = storage[bus.ReadSourceA];
        bus.ReadBusyA = is_live(bus.ReadSourceA) && pending[bus.ReadSourceA]
                      && !(eff_a && (bus.WriteTargetA == bus.ReadSourceA))
                      && !(eff_b && (bus.WriteTargetB == bus.ReadSourceA));
    end

    always_comb begin
        if (!is_live(bus.ReadSourceB))                            bus.ReadPortB = '0;
        else if (eff_a && (bus.WriteTargetA == bus.ReadSourceB)) bus.ReadPortB = bus.WriteDataA;
        else if (eff_b && (bus.WriteTargetB == bus.ReadSourceB)) bus.ReadPortB = bus.WriteDataB;
        else                                                      bus.ReadPortB = storage[bus.ReadSourceB];
        bus.ReadBusyB = is_live(bus.ReadSourceB) && pending[bus.ReadSourceB]
                      && !(eff_a && (bus.WriteTargetA == bus.ReadSourceB))
                      && !(eff_b && (bus.WriteTargetB == bus.ReadSourceB));
    end

    assign bus.BusyCount     = busy_count;
    assign bus.WriteConflict = write_conflict;
endmodule

// File: tb/tb_scoreboard_register_file.sv
// tb_scoreboard_register_file
//   Directed vector table, hand-written reset/saturation sequence and a
//   randomized phase compared against an array-based reference model.
module tb_scoreboard_register_file;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NREG = 1 << AW;

    logic Clock;
    logic Reset;
    int   checks = 0;
    int   errors = 0;

    scoreboard_register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    scoreboard_register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(1'b1)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- vector record ----------------
    typedef struct {
        logic          wea;  logic [AW-1:0] ta; logic [DW-1:0] da;
        logic          web;  logic [AW-1:0] tb; logic [DW-1:0] db;
        logic          res;  logic [AW-1:0] rt;
        logic [AW-1:0] sa;   logic [AW-1:0] sb;
        logic [DW-1:0] ra;   logic [DW-1:0] rb;
        logic          ba;   logic          bb;
        logic [AW:0]   cnt;  logic          conf;
    } vec_t;

    function automatic vec_t mk(
        input logic wea, input int ta, input logic [DW-1:0] da,
        input logic web, input int tb, input logic [DW-1:0] db,
        input logic res, input int rt, input int sa, input int sb,
        input logic [DW-1:0] ra, input logic [DW-1:0] rb,
        input logic ba, input logic bb, input int cnt, input logic conf);
        vec_t v;
        v.wea = wea; v.ta = AW'(ta); v.da = da;
        v.web = web; v.tb = AW'(tb); v.db = db;
        v.res = res; v.rt = AW'(rt); v.sa = AW'(sa); v.sb = AW'(sb);
        v.ra = ra; v.rb = rb; v.ba = ba; v.bb = bb;
        v.cnt = (AW+1)'(cnt); v.conf = conf;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive(input vec_t v);
        bus.WriteEnableA  = v.wea; bus.WriteTargetA = v.ta; bus.WriteDataA = v.da;
        bus.WriteEnableB  = v.web; bus.WriteTargetB = v.tb; bus.WriteDataB = v.db;
        bus.ReserveEnable = v.res; bus.ReserveTarget = v.rt;
        bus.ReadSourceA   = v.sa;  bus.ReadSourceB  = v.sb;
    endtask

    task automatic drive_idle();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs are applied 1 time unit after a rising edge; combinational
    // outputs are checked mid-cycle and registered ones just after the edge.
    task automatic run_vec(input vec_t v, input string tag);
        drive(v);
        #2;
        check({tag, " ReadPortA"}, bus.ReadPortA, v.ra);
        check({tag, " ReadPortB"}, bus.ReadPortB, v.rb);
        check({tag, " ReadBusyA"}, DW'(bus.ReadBusyA), DW'(v.ba));
        check({tag, " ReadBusyB"}, DW'(bus.ReadBusyB), DW'(v.bb));
        @(posedge Clock);
        #1;
        check({tag, " BusyCount"}, DW'(bus.BusyCount), DW'(v.cnt));
        check({tag, " WriteConflict"}, DW'(bus.WriteConflict), DW'(v.conf));
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        drive_idle();
        @(posedge Clock);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem  [NREG];
    logic          m_pend [NREG];

    task automatic model_clear();
        for (int i = 0; i < NREG; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Builds the expected outputs for stimulus v from the register-file rules,
    // then advances the model state to after the edge.
    task automatic model_step(inout vec_t v);
        bit ea, eb, eb_any;
        int pc;
        logic [AW-1:0] s [2];
        logic [DW-1:0] rd [2];
        logic bz [2];
        ea     = v.wea && (v.ta != 0);
        eb_any = v.web && (v.tb != 0);
        eb     = eb_any && !(ea && v.ta == v.tb);
        s[0] = v.sa; s[1] = v.sb;
        for (int p = 0; p < 2; p++) begin
            if (s[p] == 0)                rd[p] = '0;
            else if (ea && v.ta == s[p])  rd[p] = v.da;
            else if (eb && v.tb == s[p])  rd[p] = v.db;
            else                          rd[p] = m_mem[s[p]];
            bz[p] = (s[p] != 0) && m_pend[s[p]] && !(ea && v.ta == s[p]) && !(eb_any && v.tb == s[p]);
        end
        v.ra = rd[0]; v.rb = rd[1]; v.ba = bz[0]; v.bb = bz[1];
        if (ea) begin m_mem[v.ta] = v.da; m_pend[v.ta] = 1'b0; end
        if (eb) begin m_mem[v.tb] = v.db; m_pend[v.tb] = 1'b0; end
        if (v.res && v.rt != 0) m_pend[v.rt] = 1'b1;
        pc = 0;
        for (int i = 0; i < NREG; i++) pc += int'(m_pend[i]);
        v.cnt  = (AW+1)'(pc);
        v.conf = ea && v.web && (v.tb == v.ta);
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NREG - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    // ---------------- test sequence ----------------
    vec_t tbl [15];

    initial begin
        //            wea ta da          web tb db      res rt sa sb  ra           rb           ba bb cnt conf
        tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0, 5, 5,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0,       0, 0, 5, 0,  32'hDEADBEEF, 0,            0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0,            1, 0, 32'h1234,0, 0, 0, 0,  0,            0,            0, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0,       1, 0, 0, 0,  0,            0,            0, 0, 0, 0);
        tbl[4]  = mk(1, 7, 32'h11,       1, 7, 32'h22,  0, 0, 7, 7,  32'h11,       32'h11,       0, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  32'h11,       0,            0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0,       1, 3, 3, 0,  0,            0,            0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0,       1, 4, 3, 4,  0,            0,            1, 0, 2, 0);
        tbl[8]  = mk(0, 0, 0,            1, 3, 32'h33,  0, 0, 3, 4,  32'h33,       0,            0, 1, 1, 0);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0,       0, 0, 3, 4,  32'h33,       0,            0, 1, 1, 0);
        tbl[10] = mk(0, 0, 0,            0, 0, 0,       1, 9, 9, 0,  0,            0,            0, 0, 2, 0);
        tbl[11] = mk(1, 9, 32'hAA,       0, 0, 0,       1, 9, 9, 0,  32'hAA,       0,            0, 0, 2, 0);
        tbl[12] = mk(0, 0, 0,            0, 0, 0,       0, 0, 9, 4,  32'hAA,       0,            1, 1, 2, 0);
        tbl[13] = mk(1, 4, 32'h44,       1, 9, 32'h99,  0, 0, 4, 9,  32'h44,       32'h99,       0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0,            0, 0, 0,       0, 0, 4, 9,  32'h44,       32'h99,       0, 0, 0, 0);

        Reset = 1'b1;
        drive_idle();
        @(posedge Clock);
        #1;
        check("reset BusyCount", DW'(bus.BusyCount), 0);
        check("reset WriteConflict", DW'(bus.WriteConflict), 0);
        do_reset();
        check("post-reset ReadPortA", bus.ReadPortA, 0);

        for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Fill the scoreboard with r1..r31, then reset in the middle of a write.
        do_reset();
        for (int i = 1; i < NREG; i++) begin
            drive(mk(0, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0, 0, 0, 0, 0));
            @(posedge Clock);
            #1;
        end
        drive_idle();
        check("fill BusyCount", DW'(bus.BusyCount), 31);
        bus.ReadSourceA = 5'd20;
        #1;
        check("fill ReadBusyA r20", DW'(bus.ReadBusyA), 1);
        drive(mk(1, 12, 32'h5555, 1, 13, 32'h6666, 0, 0, 12, 13, 0, 0, 0, 0, 0, 0));
        #1;
        check("pre-reset bypass r12", bus.ReadPortA, 32'h5555);
        Reset = 1'b1;
        #1;
        check("mid-reset ReadPortA", bus.ReadPortA, 0);
        check("mid-reset ReadPortB", bus.ReadPortB, 0);
        check("mid-reset ReadBusyA", DW'(bus.ReadBusyA), 0);
        check("mid-reset BusyCount", DW'(bus.BusyCount), 0);
        check("mid-reset WriteConflict", DW'(bus.WriteConflict), 0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 12, 13, 0, 0, 0, 0, 0, 0));
        @(posedge Clock);
        #1;
        check("post-reset r12 not committed", bus.ReadPortA, 0);
        check("post-reset r13 not committed", bus.ReadPortB, 0);
        check("post-reset BusyCount", DW'(bus.BusyCount), 0);

        // Randomized phase against the model.
        do_reset();
        model_clear();
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            v.wea = ($urandom_range(0, 1) == 1); v.ta = rnd_addr(); v.da = $urandom;
            v.web = ($urandom_range(0, 1) == 1); v.tb = ($urandom_range(0, 5) == 0) ? v.ta : rnd_addr();
            v.db  = $urandom;
            v.res = ($urandom_range(0, 2) != 0); v.rt = ($urandom_range(0, 5) == 0) ? v.ta : rnd_addr();
            v.sa  = rnd_addr(); v.sb = ($urandom_range(0, 3) == 0) ? v.tb : rnd_addr();
            model_step(v);
            run_vec(v, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scoreboard_register_file.md
# scoreboard_register_file

Parametrised two-write / two-read general-purpose register file with per-register pending (scoreboard) tracking, same-cycle write-to-read bypass, and an asynchronous clear of all state. It sits between the decode stage and the ALU/load writeback paths. Decode reads operands and reserves destinations here. The two writeback sources commit results and release reservations.

## Interface
- DATA_WIDTH, 32: register width in bits.
- ADDR_WIDTH, 5: register index width; depth is 2^ADDR_WIDTH.
- ZERO_REG, 1: when 1, register 0 reads as zero, ignores writes and never becomes pending.

- Clock  in  1  sole clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all registers, pending bits and counters.
- WriteDataA  in  DATA_WIDTH  writeback port A data (ALU path).
- WriteTargetA  in  ADDR_WIDTH  port A destination.
- WriteEnableA  in  1  port A commit strobe.
- WriteDataB  in  DATA_WIDTH  writeback port B data (load path).
- WriteTargetB  in  ADDR_WIDTH  port B destination.
- WriteEnableB  in  1  port B commit strobe.
- ReserveEnable  in  1  mark ReserveTarget pending.
- ReserveTarget  in  ADDR_WIDTH  register to reserve.
- ReadSourceA / ReadSourceB  in  ADDR_WIDTH  read indices.
- ReadPortA / ReadPortB  out  DATA_WIDTH  read data, bypassed.
- ReadBusyA / ReadBusyB  out  1  source is pending and no write resolves it this cycle.
- BusyCount  out  ADDR_WIDTH+1  registered number of pending registers.
- WriteConflict  out  1  registered one-cycle pulse; both ports wrote the same target in the previous cycle.

## Operation
- Effective write X (X = A or B) occurs when WriteEnableX is 1 and the target is not 0 under ZERO_REG=1.
- Both ports effective with the same target: port A wins and B's data is dropped. WriteConflict is 1 in the following cycle, otherwise 0.
- Different targets: both commit on the same edge.
- An effective write clears the target's pending bit.
- An effective ReserveEnable sets the target's pending bit. If reserve and write hit the same register on the same edge, the data is committed and the bit ends set (the new producer wins).
- Reserving an already-pending register leaves it pending; BusyCount is unchanged.
- Read data priority is effective write A to the source, then effective write B, then stored value. Source 0 returns 0 under ZERO_REG=1.
- ReadBusyX = pending[ReadSourceX] AND no effective write to ReadSourceX this cycle. This is always 0 for register 0 under ZERO_REG=1. Same-cycle reserve does not affect ReadBusy.
- BusyCount next value = popcount of the pending vector after the edge. It is maintained incrementally:
  - +1 when a reserve sets a clear bit;
  - -1 for each effective write that clears a set bit not being re-reserved.
  - Range is 0..2^ADDR_WIDTH with no wrap.

## Timing
- Reset asserted, at any time including mid-write:
  - all registers = 0, all pending = 0, BusyCount = 0, WriteConflict = 0;
  - ReadPort outputs reflect zeroed storage immediately;
  - writes and reserves are ignored while Reset is high.
- Write latency:
  - the value is visible on ReadPort combinationally in the same cycle via bypass;
  - it is held in storage from the next edge.
- Reserve latency: ReadBusy rises in the cycle after the reserving edge.
- BusyCount and WriteConflict change only on rising edges or on Reset.

## Test plan
- Reset, then write 0xDEADBEEF to r5 via A; read r5 same cycle and next cycle -> 0xDEADBEEF both cycles, ReadBusy 0.
- Write 0x1234 to r0 via B with ZERO_REG=1; read r0 -> 0. Reserve r0 -> BusyCount stays 0.
- Same cycle, A writes 0x11 and B writes 0x22 to r7 -> stored r7 = 0x11, WriteConflict = 1 for exactly one cycle.
- Reserve r3 and r4 -> BusyCount 2, ReadBusy(r3) = 1. Then B writes r3 -> ReadBusy(r3) = 0 in that cycle, BusyCount 1 next cycle.
- Same edge, A writes r9 = 0xAA and reserve r9 while r9 is pending -> r9 = 0xAA, still pending, BusyCount unchanged.
- Reserve 31 distinct registers, then assert Reset mid-write -> all outputs 0 immediately, BusyCount 0, no write committed.
